// File: rtl/rob.sv
// rob: in-order reorder buffer between issue and register-file writeback.
//
// Issue allocates one slot per instruction at the tail; EX units write
// results back by slot index in any order; completed entries retire from the
// head, one per cycle, through a valid/ready commit port.
//
// Ports:
//   clock, reset_n                  clock (rising edge), async active-low reset
//   i_flush                         synchronous clear of every entry
//   i_alloc_req / o_alloc_ready     allocate one slot; o_alloc_slot is the tail index
//   i_wb_*                          NWB writeback ports (valid, idx, result, dest)
//   o_commit_* / i_commit_ready     head entry presented for retire
//   o_count, o_empty                occupancy
module rob #(
    parameter int ROB_DEPTHLOG2 = 4,
    parameter int NWB           = 2
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         i_flush,
    input  logic                         i_alloc_req,
    output logic                         o_alloc_ready,
    output logic [ROB_DEPTHLOG2-1:0]     o_alloc_slot,
    input  logic [NWB-1:0]               i_wb_valid,
    input  logic [NWB*ROB_DEPTHLOG2-1:0] i_wb_idx,
    input  logic [NWB*32-1:0]            i_wb_result,
    input  logic [NWB*5-1:0]             i_wb_dest_reg,
    input  logic [NWB-1:0]               i_wb_dest_reg_valid,
    output logic                         o_commit_valid,
    input  logic                         i_commit_ready,
    output logic [ROB_DEPTHLOG2-1:0]     o_commit_slot,
    output logic [31:0]                  o_commit_result,
    output logic [4:0]                   o_commit_dest_reg,
    output logic                         o_commit_dest_reg_valid,
    output logic [ROB_DEPTHLOG2:0]       o_count,
    output logic                         o_empty
);
    localparam int D     = ROB_DEPTHLOG2;
    localparam int DEPTH = 1 << D;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [D:0]       r_head, r_tail;
    logic [DEPTH-1:0] r_alloc, r_done;
    logic [31:0]      r_result [DEPTH];
    logic [4:0]       r_dest [DEPTH];
    logic             r_dvalid [DEPTH];

    logic [D-1:0] w_hidx, w_tidx;
    logic [D:0]   w_count;
    logic         w_grant, w_retire;

    assign w_hidx   = r_head[D-1:0];
    assign w_tidx   = r_tail[D-1:0];
    assign w_count  = r_tail - r_head;
    assign w_grant  = i_alloc_req & o_alloc_ready;
    assign w_retire = o_commit_valid & i_commit_ready;

    assign o_count        = w_count;
    assign o_empty        = w_count == '0;
    assign o_alloc_ready  = w_count != (D+1)'(DEPTH);
    assign o_alloc_slot   = w_tidx;
    assign o_commit_valid = !o_empty & r_done[w_hidx];
    assign o_commit_slot  = w_hidx;
    // Entry data is never reset, so the commit data is masked until valid.
    assign o_commit_result         = o_commit_valid ? r_result[w_hidx] : '0;
    assign o_commit_dest_reg       = o_commit_valid ? r_dest[w_hidx] : '0;
    assign o_commit_dest_reg_valid = o_commit_valid & r_dvalid[w_hidx];

    // Control state. Later assignments win: writeback sets done, allocation
    // (always to an unallocated slot) clears it, retire clears the head.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_alloc <= '0;
            r_done  <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_alloc <= '0;
            r_done  <= '0;
        end else begin
            for (int p = 0; p < NWB; p++)
                if (i_wb_valid[p] && r_alloc[i_wb_idx[p*D +: D]])
                    r_done[i_wb_idx[p*D +: D]] <= 1'b1;
            if (w_grant) begin
                r_alloc[w_tidx] <= 1'b1;
                r_done[w_tidx]  <= 1'b0;
                r_tail          <= r_tail + (D+1)'(1);
            end
            if (w_retire) begin
                r_alloc[w_hidx] <= 1'b0;
                r_done[w_hidx]  <= 1'b0;
                r_head          <= r_head + (D+1)'(1);
            end
        end
    end

    // Entry payload; iterating ports upward lets the higher port win a collision.
    always_ff @(posedge clock) begin
        for (int p = 0; p < NWB; p++)
            if (!i_flush && i_wb_valid[p] && r_alloc[i_wb_idx[p*D +: D]]) begin
                assert (!r_done[i_wb_idx[p*D +: D]]);
                r_result[i_wb_idx[p*D +: D]] <= i_wb_result[p*32 +: 32];
                r_dest[i_wb_idx[p*D +: D]]   <= i_wb_dest_reg[p*5 +: 5];
                r_dvalid[i_wb_idx[p*D +: D]] <= i_wb_dest_reg_valid[p];
            end
    end
endmodule
